// File: rtl/fsm_op_reg.sv
// Operand register: captures one request (rotate, add/sub, shift or load),
// executes it in one cycle and waits for the request to drop before re-arming.
module fsm_op_reg #(
    parameter int WIDTH    = 16,
    parameter int VAL_W    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             check,
    input  logic [1:0]       mode,
    input  logic             direction,
    input  logic [VAL_W-1:0] value,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             zero,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_HOLD = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic               dir_q, dir_d;
    logic [VAL_W-1:0]   val_q, val_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   v_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH-1:0]   res_count_s;
    logic               res_carry_s;

    // State, operand latches and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= 2'b00;
            dir_q   <= 1'b0;
            val_q   <= {VAL_W{1'b0}};
            count_q <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            val_q   <= val_d;
            count_q <= count_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    // Next-state: a held enable parks in HOLD, so only one operation runs
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable && check) state_d = S_EXEC;
                else                 state_d = S_IDLE;
            end
            S_EXEC: state_d = S_HOLD;
            S_HOLD: begin
                if (enable) state_d = S_HOLD;
                else        state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operation result from the latched operands only
    always_comb begin
        v_s         = WIDTH'(val_q);
        sum_s       = {1'b0, count_q} + {1'b0, v_s};
        diff_s      = {1'b0, count_q} - {1'b0, v_s};
        res_count_s = count_q;
        res_carry_s = 1'b0;
        case (mode_q)
            2'b00: begin
                if (dir_q) begin
                    res_count_s = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
                    res_carry_s = count_q[WIDTH-1];
                end else begin
                    res_count_s = {count_q[0], count_q[WIDTH-1:1]};
                    res_carry_s = count_q[0];
                end
            end
            2'b01: begin
                if (dir_q) begin
                    res_carry_s = sum_s[WIDTH];
                    if (SATURATE && sum_s[WIDTH]) res_count_s = {WIDTH{1'b1}};
                    else                          res_count_s = sum_s[WIDTH-1:0];
                end else begin
                    res_carry_s = diff_s[WIDTH];
                    if (SATURATE && diff_s[WIDTH]) res_count_s = {WIDTH{1'b0}};
                    else                           res_count_s = diff_s[WIDTH-1:0];
                end
            end
            2'b10: begin
                // Carry flags any set bit that falls off the end
                if (32'(val_q) >= WIDTH) begin
                    res_count_s = {WIDTH{1'b0}};
                    res_carry_s = |count_q;
                end else if (dir_q) begin
                    res_count_s = count_q << val_q;
                    res_carry_s = |(count_q & ~({WIDTH{1'b1}} >> val_q));
                end else begin
                    res_count_s = count_q >> val_q;
                    res_carry_s = |(count_q & ~({WIDTH{1'b1}} << val_q));
                end
            end
            2'b11: begin
                if (dir_q) res_count_s = v_s;
                else       res_count_s = {WIDTH{1'b0}};
                res_carry_s = 1'b0;
            end
            default: begin
                res_count_s = count_q;
                res_carry_s = 1'b0;
            end
        endcase
    end

    // Per-state register updates: capture in IDLE, commit in EXEC
    always_comb begin
        mode_d  = mode_q;
        dir_d   = dir_q;
        val_d   = val_q;
        count_d = count_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && check) begin
                    mode_d = mode;
                    dir_d  = direction;
                    val_d  = value;
                end else begin
                    mode_d = mode_q;
                end
            end
            S_EXEC: begin
                count_d = res_count_s;
                carry_d = res_carry_s;
                zero_d  = (res_count_s == {WIDTH{1'b0}});
                done_d  = 1'b1;
            end
            S_HOLD: done_d = 1'b0;
            default: done_d = 1'b0;
        endcase
    end

    assign count = count_q;
    assign carry = carry_q;
    assign zero  = zero_q;
    assign done  = done_q;

endmodule

// File: tb/tb_fsm_op_reg.sv
// Directed bench for fsm_op_reg: a wrapping and a saturating instance share stimulus.
module tb_fsm_op_reg;

    logic        clock = 1'b0;
    logic        reset, enable, check, direction;
    logic [1:0]  mode;
    logic [3:0]  value;
    logic [15:0] count0, count1;
    logic        carry0, carry1, zero0, zero1, done0, done1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  m;
        logic        d;
        logic [3:0]  v;
        logic [15:0] c0;
        logic        k0;
        logic [15:0] c1;
        logic        k1;
    } vec_t;

    vec_t tbl[22];

    fsm_op_reg #(.WIDTH(16), .VAL_W(4), .SATURATE(1'b0)) dut0 (
        .clock(clock), .reset(reset), .enable(enable), .check(check),
        .mode(mode), .direction(direction), .value(value),
        .count(count0), .carry(carry0), .zero(zero0), .done(done0)
    );

    fsm_op_reg #(.WIDTH(16), .VAL_W(4), .SATURATE(1'b1)) dut1 (
        .clock(clock), .reset(reset), .enable(enable), .check(check),
        .mode(mode), .direction(direction), .value(value),
        .count(count1), .carry(carry1), .zero(zero1), .done(done1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One-cycle request; checks the done pulse lands exactly two edges after sampling
    task automatic do_op(input logic [1:0] m, input logic d, input logic [3:0] v);
        @(negedge clock);
        mode = m; direction = d; value = v; enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        chk("done_exec", {31'd0, done0}, 32'd0);
        @(negedge clock);
        chk("done_pulse", {31'd0, done0}, 32'd1);
        chk("done_pulse_sat", {31'd0, done1}, 32'd1);
        @(negedge clock);
        chk("done_clear", {31'd0, done0}, 32'd0);
    endtask

    initial begin
        int dones;

        tbl[0]  = '{2'b11, 1'b0, 4'h0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[1]  = '{2'b01, 1'b1, 4'h1, 16'h0001, 1'b0, 16'h0001, 1'b0};
        tbl[2]  = '{2'b01, 1'b1, 4'h1, 16'h0002, 1'b0, 16'h0002, 1'b0};
        tbl[3]  = '{2'b01, 1'b1, 4'h1, 16'h0003, 1'b0, 16'h0003, 1'b0};
        tbl[4]  = '{2'b01, 1'b1, 4'h1, 16'h0004, 1'b0, 16'h0004, 1'b0};
        tbl[5]  = '{2'b01, 1'b1, 4'h3, 16'h0007, 1'b0, 16'h0007, 1'b0};
        tbl[6]  = '{2'b01, 1'b0, 4'h3, 16'h0004, 1'b0, 16'h0004, 1'b0};
        tbl[7]  = '{2'b01, 1'b0, 4'h3, 16'h0001, 1'b0, 16'h0001, 1'b0};
        tbl[8]  = '{2'b00, 1'b0, 4'h0, 16'h8000, 1'b1, 16'h8000, 1'b1};
        tbl[9]  = '{2'b00, 1'b1, 4'h0, 16'h0001, 1'b1, 16'h0001, 1'b1};
        tbl[10] = '{2'b00, 1'b1, 4'h0, 16'h0002, 1'b0, 16'h0002, 1'b0};
        tbl[11] = '{2'b00, 1'b1, 4'h0, 16'h0004, 1'b0, 16'h0004, 1'b0};
        tbl[12] = '{2'b11, 1'b0, 4'h0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[13] = '{2'b01, 1'b0, 4'h1, 16'hFFFF, 1'b1, 16'h0000, 1'b1};
        tbl[14] = '{2'b01, 1'b1, 4'h1, 16'h0000, 1'b1, 16'h0001, 1'b0};
        tbl[15] = '{2'b11, 1'b1, 4'hF, 16'h000F, 1'b0, 16'h000F, 1'b0};
        tbl[16] = '{2'b10, 1'b1, 4'h4, 16'h00F0, 1'b0, 16'h00F0, 1'b0};
        tbl[17] = '{2'b10, 1'b0, 4'h4, 16'h000F, 1'b0, 16'h000F, 1'b0};
        tbl[18] = '{2'b10, 1'b0, 4'h8, 16'h0000, 1'b1, 16'h0000, 1'b1};
        tbl[19] = '{2'b11, 1'b1, 4'h5, 16'h0005, 1'b0, 16'h0005, 1'b0};
        tbl[20] = '{2'b10, 1'b1, 4'h0, 16'h0005, 1'b0, 16'h0005, 1'b0};
        tbl[21] = '{2'b10, 1'b1, 4'hF, 16'h8000, 1'b1, 16'h8000, 1'b1};

        reset = 1'b1; enable = 1'b0; check = 1'b1;
        mode = 2'b00; direction = 1'b0; value = 4'h0;
        repeat (3) @(negedge clock);
        chk("rst_count", {16'd0, count0}, 32'd0);
        chk("rst_carry", {31'd0, carry0}, 32'd0);
        chk("rst_zero", {31'd0, zero0}, 32'd1);
        chk("rst_done", {31'd0, done0}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            do_op(tbl[i].m, tbl[i].d, tbl[i].v);
            chk($sformatf("count[%0d]", i), {16'd0, count0}, {16'd0, tbl[i].c0});
            chk($sformatf("carry[%0d]", i), {31'd0, carry0}, {31'd0, tbl[i].k0});
            chk($sformatf("zero[%0d]", i), {31'd0, zero0}, {31'd0, (tbl[i].c0 == 16'h0000)});
            chk($sformatf("sat_count[%0d]", i), {16'd0, count1}, {16'd0, tbl[i].c1});
            chk($sformatf("sat_carry[%0d]", i), {31'd0, carry1}, {31'd0, tbl[i].k1});
            chk($sformatf("sat_zero[%0d]", i), {31'd0, zero1}, {31'd0, (tbl[i].c1 == 16'h0000)});
        end

        // Held enable: one operation; operand changes after capture are ignored
        do_op(2'b11, 1'b1, 4'h1);
        @(negedge clock);
        mode = 2'b01; direction = 1'b1; value = 4'h2; enable = 1'b1;
        dones = 0;
        @(negedge clock);
        mode = 2'b11; direction = 1'b0; value = 4'h7;
        for (int i = 0; i < 9; i++) begin
            if (done0) dones = dones + 1;
            @(negedge clock);
        end
        if (done0) dones = dones + 1;
        chk("held_dones", dones, 32'd1);
        chk("held_count", {16'd0, count0}, 32'h0003);
        enable = 1'b0;
        repeat (2) @(negedge clock);
        chk("held_stable", {16'd0, count0}, 32'h0003);
        do_op(2'b01, 1'b1, 4'h2);
        chk("rearm_count", {16'd0, count0}, 32'h0005);

        // check low: request ignored
        check = 1'b0;
        @(negedge clock);
        enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            if (done0) dones = dones + 1;
            @(negedge clock);
        end
        chk("nocheck_dones", dones, 32'd0);
        chk("nocheck_count", {16'd0, count0}, 32'h0005);
        check = 1'b1;

        // Reset during EXEC discards the operation
        @(negedge clock);
        mode = 2'b01; direction = 1'b1; value = 4'h1; enable = 1'b1;
        @(negedge clock);
        enable = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rstx_count", {16'd0, count0}, 32'd0);
        chk("rstx_zero", {31'd0, zero0}, 32'd1);
        chk("rstx_done", {31'd0, done0}, 32'd0);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (done0) dones = dones + 1;
        end
        chk("rstx_nodone", dones, 32'd0);
        do_op(2'b01, 1'b1, 4'h1);
        chk("after_rst_count", {16'd0, count0}, 32'h0001);
        chk("after_rst_zero", {31'd0, zero0}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
